// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer: select encoding
// (identical to mux_4_1) and default widths.
package demux_pkg;

    localparam logic [1:0] SEL_OUT1 = 2'b00;
    localparam logic [1:0] SEL_OUT2 = 2'b01;
    localparam logic [1:0] SEL_OUT3 = 2'b10;
    localparam logic [1:0] SEL_OUT4 = 2'b11;

    localparam int DEFAULT_N  = 32;
    localparam int DEFAULT_CW = 8;
    localparam int NUM_OUTS   = 4;

    // One-hot load strobe for the output addressed by sel.
    function automatic logic [NUM_OUTS-1:0] sel_onehot(input logic [1:0] sel);
        logic [NUM_OUTS-1:0] oh;
        oh = '0;
        case (sel)
            SEL_OUT1: oh[0] = 1'b1;
            SEL_OUT2: oh[1] = 1'b1;
            SEL_OUT3: oh[2] = 1'b1;
            default:  oh[3] = 1'b1;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output slot of the demultiplexer: a one-word holding register, its full
// flag and a wrapping delivered-word counter.
module demux_slot
    import demux_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int CW = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [N-1:0]  load_data,
    input  logic          out_ready,
    output logic          full,
    output logic [N-1:0]  data,
    output logic [CW-1:0] count,
    output logic          can_load
);

    logic drain;

    assign drain    = full && out_ready;
    // A word leaving this cycle frees the slot for a word arriving this cycle.
    assign can_load = !full || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the data word is reset too because it is
    // visible on the output ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            data  <= '0;
            count <= '0;
        end else begin
            if (load) begin
                data <= load_data;
                full <= 1'b1;
            end else if (drain) begin
                full <= 1'b0;
            end
            if (drain) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer: steers each accepted
// word into one of four independent holding slots chosen by select.
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int CW = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [1:0]    select,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic [N-1:0]  output_1,
    output logic [N-1:0]  output_2,
    output logic [N-1:0]  output_3,
    output logic [N-1:0]  output_4,
    output logic [CW-1:0] count_1,
    output logic [CW-1:0] count_2,
    output logic [CW-1:0] count_3,
    output logic [CW-1:0] count_4
);

    logic [NUM_OUTS-1:0] can_load;
    logic [NUM_OUTS-1:0] load;
    logic [N-1:0]        slot_data  [NUM_OUTS];
    logic [CW-1:0]       slot_count [NUM_OUTS];

    assign in_ready = can_load[select];
    assign load     = (in_valid && in_ready) ? sel_onehot(select) : '0;

    for (genvar k = 0; k < NUM_OUTS; k++) begin : g_slot
        demux_slot #(
            .N  (N),
            .CW (CW)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .full      (out_valid[k]),
            .data      (slot_data[k]),
            .count     (slot_count[k]),
            .can_load  (can_load[k])
        );
    end

    assign output_1 = slot_data[0];
    assign output_2 = slot_data[1];
    assign output_3 = slot_data[2];
    assign output_4 = slot_data[3];

    assign count_1 = slot_count[0];
    assign count_2 = slot_count[1];
    assign count_3 = slot_count[2];
    assign count_4 = slot_count[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: directed scenarios plus random
// traffic compared against a per-slot behavioural model.
module tb_demux_1_4_stream;

    localparam int N  = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [1:0]    select;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [N-1:0]  output_1, output_2, output_3, output_4;
    logic [CW-1:0] count_1, count_2, count_3, count_4;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: what each output should be holding and has delivered.
    logic          m_full  [4];
    logic [N-1:0]  m_data  [4];
    logic [CW-1:0] m_count [4];

    demux_1_4_stream #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .output_1  (output_1),
        .output_2  (output_2),
        .output_3  (output_3),
        .output_4  (output_4),
        .count_1   (count_1),
        .count_2   (count_2),
        .count_3   (count_3),
        .count_4   (count_4)
    );

    always #5 clk = ~clk;

    // Producer rule: a stalled offer must hold its data and select.
    logic          prev_stall = 1'b0;
    logic [N-1:0]  prev_data;
    logic [1:0]    prev_sel;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                assert (in_valid && in_data == prev_data && select == prev_sel)
                    else $error("producer changed a stalled offer");
            prev_stall <= in_valid && !in_ready;
            prev_data  <= in_data;
            prev_sel   <= select;
        end
    end

    function automatic logic [N-1:0] obs_data(input int k);
        case (k)
            0: return output_1;
            1: return output_2;
            2: return output_3;
            default: return output_4;
        endcase
    endfunction

    function automatic logic [CW-1:0] obs_count(input int k);
        case (k)
            0: return count_1;
            1: return count_2;
            2: return count_3;
            default: return count_4;
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            m_full[k]  = 1'b0;
            m_data[k]  = '0;
            m_count[k] = '0;
        end
    endtask

    // Drives one cycle, samples in_ready before the edge, advances the model.
    task automatic step(input logic v, input logic [1:0] s, input logic [N-1:0] d,
                        input logic [3:0] r, output logic rdy, output logic exp_rdy);
        logic drain;
        in_valid  = v;
        select    = s;
        in_data   = d;
        out_ready = r;
        #1;
        rdy     = in_ready;
        exp_rdy = !m_full[s] || r[s];
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            drain = m_full[k] && r[k];
            if (drain) m_count[k] = m_count[k] + 1'b1;
            if (v && exp_rdy && s == 2'(k)) begin
                m_data[k] = d;
                m_full[k] = 1'b1;
            end else if (drain) begin
                m_full[k] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        logic rdy, erdy;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        select    = 2'b00;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 4'b0000;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 4'b0000) $display("FAIL reset_out_valid got %b want 0000", out_valid);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_data(k) !== '0) $display("FAIL reset_output_%0d got %h want 0", k + 1, obs_data(k));
            else n_pass++;
            n_checks++;
            if (obs_count(k) !== '0) $display("FAIL reset_count_%0d got %0d want 0", k + 1, obs_count(k));
            else n_pass++;
        end
        rst_n = 1'b1;
        step(1'b1, 2'b00, 32'h0000_0055, 4'b0000, rdy, erdy);
        n_checks++;
        if (rdy !== 1'b1 || output_1 !== 32'h55 || out_valid !== 4'b0001)
            $display("FAIL reset_first_word got rdy=%b out1=%h valid=%b want 1/55/0001",
                     rdy, output_1, out_valid);
        else n_pass++;
    endtask

    task automatic test_routing();
        logic rdy, erdy;
        logic [N-1:0] words [4];
        words[0] = 32'hA1; words[1] = 32'hB2; words[2] = 32'hC3; words[3] = 32'hD4;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'(k), words[k], 4'b1111, rdy, erdy);
            n_checks++;
            if (rdy !== 1'b1 || obs_data(k) !== words[k] || out_valid[k] !== 1'b1)
                $display("FAIL routing_out%0d got rdy=%b data=%h valid=%b want 1/%h/1",
                         k + 1, rdy, obs_data(k), out_valid[k], words[k]);
            else n_pass++;
        end
        step(1'b0, 2'b00, '0, 4'b1111, rdy, erdy);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_count(k) !== 8'd1) $display("FAIL routing_count_%0d got %0d want 1", k + 1, obs_count(k));
            else n_pass++;
        end
        n_checks++;
        if (out_valid !== 4'b0000) $display("FAIL routing_drained got %b want 0000", out_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic rdy, erdy;
        apply_reset();
        step(1'b1, 2'b10, 32'h11, 4'b1011, rdy, erdy);
        n_checks++;
        if (output_3 !== 32'h11 || out_valid[2] !== 1'b1)
            $display("FAIL bp_hold got out3=%h valid=%b want 11/1", output_3, out_valid[2]);
        else n_pass++;
        step(1'b1, 2'b10, 32'h22, 4'b1011, rdy, erdy);
        n_checks++;
        if (rdy !== 1'b0 || output_3 !== 32'h11)
            $display("FAIL bp_stall got rdy=%b out3=%h want 0/11", rdy, output_3);
        else n_pass++;
        step(1'b1, 2'b10, 32'h22, 4'b1111, rdy, erdy);
        n_checks++;
        if (rdy !== 1'b1 || output_3 !== 32'h22 || out_valid[2] !== 1'b1 || count_3 !== 8'd1)
            $display("FAIL bp_release got rdy=%b out3=%h valid=%b cnt=%0d want 1/22/1/1",
                     rdy, output_3, out_valid[2], count_3);
        else n_pass++;
    endtask

    task automatic test_independence();
        logic rdy, erdy;
        logic [N-1:0] d;
        apply_reset();
        step(1'b1, 2'b01, 32'h77, 4'b1101, rdy, erdy);
        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            step(1'b1, 2'b00, d, 4'b1101, rdy, erdy);
            n_checks++;
            if (rdy !== 1'b1 || output_1 !== d || out_valid[1:0] !== 2'b11 || output_2 !== 32'h77)
                $display("FAIL indep_%0d got rdy=%b out1=%h valid=%b out2=%h want 1/%h/11/77",
                         i, rdy, output_1, out_valid[1:0], output_2, d);
            else n_pass++;
        end
        n_checks++;
        if (count_1 !== 8'd19 || count_2 !== 8'd0)
            $display("FAIL indep_counts got c1=%0d c2=%0d want 19/0", count_1, count_2);
        else n_pass++;
    endtask

    task automatic test_counter_wrap();
        logic rdy, erdy;
        apply_reset();
        step(1'b1, 2'b00, 32'h5, 4'b1111, rdy, erdy);
        step(1'b1, 2'b01, 32'h6, 4'b1111, rdy, erdy);
        for (int i = 0; i < 256; i++) step(1'b1, 2'b11, $urandom, 4'b1011, rdy, erdy);
        n_checks++;
        if (count_4 !== 8'd255) $display("FAIL wrap_255 got %0d want 255", count_4);
        else n_pass++;
        step(1'b0, 2'b11, '0, 4'b1000, rdy, erdy);
        n_checks++;
        if (count_4 !== 8'd0 || count_1 !== 8'd1 || count_2 !== 8'd1 || count_3 !== 8'd0)
            $display("FAIL wrap_0 got c4=%0d c1=%0d c2=%0d c3=%0d want 0/1/1/0",
                     count_4, count_1, count_2, count_3);
        else n_pass++;
    endtask

    task automatic test_random();
        logic rdy, erdy, v;
        logic [1:0] s;
        logic [N-1:0] d;
        logic stalled;
        int errs;
        apply_reset();
        stalled = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!stalled) begin
                v = ($urandom_range(3) != 0);
                s = 2'($urandom_range(3));
                d = $urandom;
            end
            step(v, s, d, 4'($urandom), rdy, erdy);
            stalled = v && !rdy;
            errs = 0;
            if (rdy !== erdy) errs++;
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] !== m_full[k]) errs++;
                if (m_full[k] && obs_data(k) !== m_data[k]) errs++;
                if (obs_count(k) !== m_count[k]) errs++;
            end
            n_checks++;
            if (errs != 0)
                $display("FAIL random_%0d got rdy=%b valid=%b c=%0d/%0d/%0d/%0d want rdy=%b valid=%b%b%b%b c=%0d/%0d/%0d/%0d",
                         i, rdy, out_valid, count_1, count_2, count_3, count_4, erdy,
                         m_full[3], m_full[2], m_full[1], m_full[0],
                         m_count[0], m_count[1], m_count[2], m_count[3]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midstream();
        logic rdy, erdy;
        apply_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 2'(k), $urandom, 4'b1111, rdy, erdy);
        step(1'b0, 2'b00, '0, 4'b1111, rdy, erdy);
        for (int k = 0; k < 4; k++) step(1'b1, 2'(k), $urandom, 4'b0000, rdy, erdy);
        n_checks++;
        if (out_valid !== 4'b1111 || count_2 !== 8'd1)
            $display("FAIL mid_filled got valid=%b c2=%0d want 1111/1", out_valid, count_2);
        else n_pass++;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 4'b0000 || count_1 !== '0 || count_2 !== '0 || count_3 !== '0 || count_4 !== '0)
            $display("FAIL mid_async got valid=%b c=%0d/%0d/%0d/%0d want 0000/0/0/0/0",
                     out_valid, count_1, count_2, count_3, count_4);
        else n_pass++;
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_independence();
        test_counter_wrap();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_1_4_stream.md
# demux_1_4_stream

Registered 1-to-4 stream demultiplexer: the write-side counterpart of `mux_4_1`. It steers one valid/ready input stream of N-bit words to one of four output streams, chosen by a 2-bit select. Each output has a one-word holding register and a delivered-word counter. It sits wherever a single producer fans out to four consumers, for example a write-back or dispatch bus feeding four units.

## Interface
Parameters:
- `N`, 32, data word width
- `CW`, 8, width of each per-output delivered-word counter

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `in_valid`  in  1  producer has a word
- `in_ready`  out  1  word accepted this cycle when `in_valid && in_ready`
- `in_data`  in  N  input word
- `select`  in  2  destination: 00 → output_1, 01 → output_2, 10 → output_3, 11 → output_4 (same encoding as `mux_4_1`)
- `out_valid[3:0]`  out  4  bit k: output_(k+1) holds a word
- `out_ready[3:0]`  in  4  bit k: consumer k+1 takes its word
- `output_1`..`output_4`  out  N each  registered output words
- `count_1`..`count_4`  out  CW each  words delivered on each output

## Operation
- Each output k has a slot: `full_k` (drives `out_valid[k]`) and `data_k` (drives `output_(k+1)`).
- `in_ready = !full[select] || out_ready[select]`. This is combinational from `select`, the slot state and `out_ready`. It never depends on `in_valid`.
- Accept (`in_valid && in_ready`): `data[select] <= in_data`, `full[select] <= 1`.
- Drain on output k (`full_k && out_ready[k]`):
  - `full_k <= 0`, unless an accept targets k in the same cycle.
  - `count_k <= count_k + 1`, modulo 2^CW (wraps from 2^CW−1 to 0).
- Accept and drain on the same slot in the same cycle: the slot stays full with the new word, and the counter increments.
- Slots are independent. Draining one output never stalls or alters another.
- Producer rule: while `in_valid && !in_ready`, `in_data` and `select` must stay stable. The bench asserts this rule; the RTL does not check it.
- `output_k` holds its last value after a drain. It is meaningful only while `out_valid[k]` is high.

## Timing
- Reset values (async, on `rst_n` low): `out_valid` = 0000, all `output_k` = 0, all `count_k` = 0.
- `in_ready` during reset = 1. Words offered during reset are not captured.
- Reset mid-operation: all buffered words are dropped and the counters cleared, immediately (asynchronous, not at the next edge).
- Latency: a word accepted at edge t appears on `output_k` with `out_valid[k]` = 1 after edge t.
- Throughput: one word per cycle into a slot whose consumer holds `out_ready` high.
- No combinational path from `in_data` to any output. The only combinational paths are `select` and `out_ready` to `in_ready`.

## Structure
- Shared package `demux_pkg`:
  - constants `SEL_OUT1`..`SEL_OUT4` (2'b00..2'b11)
  - default `N`
- One sub-module, `demux_slot`, instantiated four times. It contains the one-word register, the full flag and the CW-bit counter.
  - Inputs: `clk`, `rst_n`, `load`, `load_data`, `out_ready`.
  - Outputs: `full`, `data`, `count`, `can_load` (= `!full || out_ready`).
- The top level holds only the select decode, which forms the four `load` strobes. `in_ready` is `can_load[select]`.

## Test plan
- **Reset**: hold `rst_n`=0 with `in_valid`=1. Require `out_valid`=0000, all outputs 0, all counts 0. Release reset; the first word is then accepted normally.
- **Routing**: with `out_ready`=1111, send 0xA1, 0xB2, 0xC3, 0xD4 with select 0, 1, 2, 3 on consecutive cycles.
  - Require each word on output_1..output_4 respectively, one cycle after its accept.
  - Require `count_1`..`count_4` = 1 each.
- **Backpressure**: `out_ready[2]`=0; send 0x11 then 0x22, both with select=2.
  - Require 0x11 held on output_3 and `in_ready`=0 for the second word.
  - Raise `out_ready[2]`: 0x11 drains, 0x22 is accepted in the same cycle, and `out_valid[2]` stays 1.
- **Independence**: with output_2 stalled and full, send select=0 words at `in_valid`=1 every cycle.
  - Require `in_ready`=1 and one delivery per cycle on output_1.
  - Require output_2 unchanged.
- **Counter wrap**: with CW=8, deliver 256 words to output_4. Require `count_4` 255 → 0, with the other counts unchanged.
- **Reset mid-stream**: fill all four slots, then pulse `rst_n` low between clock edges. Require an immediate `out_valid`=0000 and all counts 0, with no edge needed.
